rp_seq_ctrl: RTL and testbench
==============================

Name: rp_seq_ctrl

Overview:
- Parametrised segment-sequencing controller for the reduced-precision/pruned HDC datapath.
- Steps a segment index through a hypervector during feature bundling or query-vs-class comparison, so the encoding/compare MUX processes one segment per transfer.
- Adds a runtime prune depth (`keep_segs`), a valid/ready handshake to the datapath, a pipeline drain phase, abort, and a done pulse.

Parameters:
- `NUM_SEG`, 4: total segments per hypervector (≥1).
- `PIPE_LAT`, 2: datapath pipeline depth drained after the last segment issues (≥0).
- `IDX_W`, max(1, clog2(NUM_SEG)): segment index width (derived).
- `CNT_W`, clog2(NUM_SEG+1): segment count width (derived).

Ports:
- `clk`, in, 1: clock, rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `en`, in, 1: global enable. When low, all state and counters freeze.
- `start_bundle`, in, 1: request a bundling pass.
- `start_compare`, in, 1: request a comparison pass.
- `keep_segs`, in, CNT_W: number of leading segments to process. Sampled at start.
- `seg_ready`, in, 1: datapath accepts the current segment.
- `abort`, in, 1: cancel the current pass.
- `seg_idx`, out, IDX_W: current segment select.
- `seg_valid`, out, 1: `seg_idx` is presented to the datapath.
- `seg_first`, out, 1: current segment is index 0.
- `seg_last`, out, 1: current segment is index keep-1.
- `mode`, out, 1: 0 = bundle, 1 = compare. Latched at start.
- `busy`, out, 1: a pass is in progress.
- `done`, out, 1: one-cycle completion pulse.

Behaviour:
- Reset (async, `rst`=1):
  - State goes to IDLE.
  - `seg_idx`, `mode`, the drain counter, latched keep, and all outputs are 0.
- States: IDLE, ISSUE, DRAIN, DONE. All outputs decode from registered state/counters (Moore).
- IDLE:
  - On `en` && (`start_bundle` || `start_compare`): latch `mode` (`start_bundle` wins if both are high, giving `mode`=0).
  - Latch keep = min(`keep_segs`, NUM_SEG).
  - If keep == 0, go to DONE. Otherwise go to ISSUE with `seg_idx`=0.
- ISSUE:
  - `seg_valid`=1 and `busy`=1.
  - Transfer occurs when `seg_valid` && `seg_ready` && `en`.
  - `seg_idx`, `seg_first` and `seg_last` are held stable until the transfer.
  - On transfer of a non-last segment: `seg_idx` += 1.
  - On transfer of the last segment: `seg_idx` goes to 0. Next state is DRAIN, or DONE if PIPE_LAT == 0.
- DRAIN:
  - `busy`=1, `seg_valid`=0.
  - Drain counter runs 0 … PIPE_LAT-1, advancing only while `en`=1.
  - At PIPE_LAT-1, go to DONE.
- DONE:
  - `done`=1 for exactly one cycle, `busy`=0.
  - Unconditionally return to IDLE.
  - Starts asserted during DONE are ignored and not queued.
- `seg_first` = (ISSUE && `seg_idx`==0). `seg_last` = (ISSUE && `seg_idx`==keep-1). Both are 0 outside ISSUE.
- `abort`:
  - In ISSUE, DRAIN or DONE: go to IDLE at the next edge with `seg_idx`=0, no `done` pulse.
  - Takes priority over a same-cycle transfer and over `done`.
  - Ignored in IDLE.
- `en`=0 outside IDLE freezes state, index and drain counter. `abort` and `rst` still act.
- Start requests while `busy` are ignored.
- `keep_segs` changes after start have no effect until the next start.
- The index never exceeds keep-1, so it does not wrap beyond NUM_SEG-1.
- Latency (`en`=1, `seg_ready`=1): start at edge 0, then issue cycles 1..keep, then drain for PIPE_LAT cycles, then `done` in cycle keep+PIPE_LAT+1.
- Reset asserted mid-pass: immediate return to IDLE with all outputs 0.

Test Plan (NUM_SEG=4, PIPE_LAT=2):
1. `start_bundle`, `keep_segs`=4, `seg_ready`=1 → `seg_valid` in cycles 1-4 with `seg_idx` 0,1,2,3; `seg_first` in cycle 1; `seg_last` in cycle 4; `busy` in cycles 1-6; `done` in cycle 7; `mode`=0.
2. `start_compare`, `keep_segs`=2 (pruned) → `seg_idx` 0,1 only; `seg_last` in cycle 2; `done` in cycle 5; `mode`=1. Same run with `keep_segs`=7 → clamped to 4, `done` in cycle 7.
3. `keep_segs`=4 with `seg_ready` low for 3 cycles while `seg_idx`=1 → `seg_idx` holds 1 with `seg_valid`=1, then resumes; `done` in cycle 10. Repeat with `en` low 2 cycles in DRAIN → `done` delayed by 2.
4. `keep_segs`=0 → no `seg_valid`; `done` in cycle 1. Both starts high together → `mode`=0. Start pulse while `busy` → ignored, no second pass.
5. `abort` in the cycle `seg_idx`=2 with `seg_ready`=1 → next cycle IDLE, `seg_idx`=0, `busy`=0, no `done`. `abort` in the DRAIN cycle → no `done`.
6. `rst` pulsed asynchronously mid-ISSUE (`seg_idx`=3) → outputs 0 immediately. The first start after reset runs the full sequence from idx 0.

Source files
------------

// File: rtl/rp_seq_ctrl.sv
// rp_seq_ctrl: segment-sequencing controller for the pruned HDC datapath.
// It walks a segment index across the leading keep_segs segments of a
// hypervector, one per valid/ready transfer. It then drains the datapath
// pipeline and pulses done.
//
// Ports:
//   clk, rst            clock (rising edge), async active-high reset
//   en                  global enable; low freezes the pass (abort/rst still act)
//   start_bundle        request bundling pass (wins over start_compare)
//   start_compare       request comparison pass
//   keep_segs[CNT_W]    leading segments to process, sampled at start
//   seg_ready           datapath accepts current segment
//   abort               cancel the pass in progress
//   seg_idx[IDX_W]      current segment select
//   seg_valid           seg_idx is presented to the datapath
//   seg_first/seg_last  current segment is first / last kept segment
//   mode                0 = bundle, 1 = compare (latched at start)
//   busy                pass in progress (issue or drain)
//   done                one-cycle completion pulse
//
// state    | meaning
// ---------+-------------------------------------------------
// ST_IDLE  | waiting for a start request
// ST_ISSUE | presenting seg_idx, advancing on each transfer
// ST_DRAIN | waiting PIPE_LAT enabled cycles for pipeline drain
// ST_DONE  | done pulse, back to idle next edge
module rp_seq_ctrl #(
  parameter int NUM_SEG = 4,
  parameter int PIPE_LAT = 2,
  localparam int IDX_W = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1,
  localparam int CNT_W = $clog2(NUM_SEG + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             start_bundle,
  input  logic             start_compare,
  input  logic [CNT_W-1:0] keep_segs,
  input  logic             seg_ready,
  input  logic             abort,
  output logic [IDX_W-1:0] seg_idx,
  output logic             seg_valid,
  output logic             seg_first,
  output logic             seg_last,
  output logic             mode,
  output logic             busy,
  output logic             done
);

  localparam int DRAIN_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'((PIPE_LAT > 0) ? PIPE_LAT - 1 : 0);
  localparam logic [CNT_W-1:0] NUM_SEG_C = CNT_W'(NUM_SEG);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   keep_q;
  logic [DRAIN_W-1:0] drain_cnt;
  logic [CNT_W-1:0]   keep_clamp;
  logic               at_last;

  // Clamp so the index can never run past the physical segment count.
  assign keep_clamp = (keep_segs > NUM_SEG_C) ? NUM_SEG_C : keep_segs;
  // keep_q is nonzero whenever we are in ISSUE, so keep_q-1 cannot underflow there.
  assign at_last    = (CNT_W'(seg_idx) == (keep_q - CNT_W'(1)));

  assign seg_valid = (state == ST_ISSUE);
  assign seg_first = (state == ST_ISSUE) && (seg_idx == '0);
  assign seg_last  = (state == ST_ISSUE) && at_last;
  assign busy      = (state == ST_ISSUE) || (state == ST_DRAIN);
  assign done      = (state == ST_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      seg_idx   <= '0;
      mode      <= 1'b0;
      keep_q    <= '0;
      drain_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (en && (start_bundle || start_compare)) begin
            mode      <= ~start_bundle;
            keep_q    <= keep_clamp;
            seg_idx   <= '0;
            drain_cnt <= '0;
            state     <= (keep_clamp == '0) ? ST_DONE : ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (abort) begin
            state   <= ST_IDLE;
            seg_idx <= '0;
          end else if (en && seg_ready) begin
            if (at_last) begin
              seg_idx   <= '0;
              drain_cnt <= '0;
              state     <= (PIPE_LAT == 0) ? ST_DONE : ST_DRAIN;
            end else begin
              seg_idx <= seg_idx + IDX_W'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (abort) begin
            state   <= ST_IDLE;
            seg_idx <= '0;
          end else if (en) begin
            if (drain_cnt == DRAIN_LAST) begin
              state <= ST_DONE;
            end else begin
              drain_cnt <= drain_cnt + DRAIN_W'(1);
            end
          end
        end
        ST_DONE: begin
          // Leave unconditionally so done stays a single-cycle pulse.
          state   <= ST_IDLE;
          seg_idx <= '0;
        end
        default: begin
          state   <= ST_IDLE;
          seg_idx <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rp_seq_ctrl.sv
module tb_rp_seq_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       start_bundle;
  logic       start_compare;
  logic [2:0] keep_segs;
  logic       seg_ready;
  logic       abort;
  logic [1:0] seg_idx;
  logic       seg_valid, seg_first, seg_last, mode, busy, done;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;

  rp_seq_ctrl #(.NUM_SEG(4), .PIPE_LAT(2)) dut (
    .clk(clk), .rst(rst), .en(en),
    .start_bundle(start_bundle), .start_compare(start_compare),
    .keep_segs(keep_segs), .seg_ready(seg_ready), .abort(abort),
    .seg_idx(seg_idx), .seg_valid(seg_valid), .seg_first(seg_first),
    .seg_last(seg_last), .mode(mode), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // {busy, done, seg_valid, seg_first, seg_last, mode, seg_idx}
  function automatic logic [7:0] ev(bit b, bit d, bit v, bit f, bit l, bit m, logic [1:0] idx);
    return {b, d, v, f, l, m, idx};
  endfunction

  function automatic logic [7:0] obs();
    return {busy, done, seg_valid, seg_first, seg_last, mode, seg_idx};
  endfunction

  task automatic chk(string tag, logic [31:0] o, logic [31:0] e);
    n_total = n_total + 1;
    assert (o === e) n_pass = n_pass + 1;
    else $error("FAIL %s: got %0h expected %0h", tag, o, e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc = cyc + 1;
  endtask

  // Drive a start, cross edge 0; on return we sit in cycle 1.
  task automatic start_pass(bit sb, bit sc, logic [2:0] ks);
    start_bundle  = sb;
    start_compare = sc;
    keep_segs     = ks;
    cyc = 0;
    step();
    start_bundle  = 1'b0;
    start_compare = 1'b0;
  endtask

  // From cycle 1 with seg_ready=1, en=1: keep issue cycles, 2 drain, done, idle.
  task automatic issue_seq(string tag, bit m, int keep);
    for (int i = 0; i < keep; i++) begin
      chk({tag, "_issue"}, obs(), ev(1, 0, 1, i == 0, i == keep - 1, m, 2'(i)));
      step();
    end
    for (int i = 0; i < 2; i++) begin
      chk({tag, "_drain"}, obs(), ev(1, 0, 0, 0, 0, m, 2'd0));
      step();
    end
    chk({tag, "_done"}, obs(), ev(0, 1, 0, 0, 0, m, 2'd0));
    step();
    chk({tag, "_idle"}, obs(), ev(0, 0, 0, 0, 0, m, 2'd0));
  endtask

  task automatic wait_done(string tag, int exp_cyc);
    int guard = 0;
    while (done !== 1'b1 && guard < 40) begin
      step();
      guard++;
    end
    chk({tag, "_done_cycle"}, cyc, exp_cyc);
    step();
  endtask

  task automatic no_done(string tag, int n);
    for (int i = 0; i < n; i++) begin
      chk({tag, "_quiet"}, {30'd0, busy, done}, 32'd0);
      step();
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; start_bundle = 1'b0; start_compare = 1'b0;
    keep_segs = 3'd0; seg_ready = 1'b1; abort = 1'b0;
    #12;
    chk("reset_outputs", obs(), ev(0, 0, 0, 0, 0, 0, 2'd0));
    rst = 1'b0;
    step();

    // 1: full bundle pass
    start_pass(1, 0, 3'd4);
    issue_seq("t1_bundle4", 0, 4);
    step();

    // 2: pruned compare, then clamped keep
    start_pass(0, 1, 3'd2);
    issue_seq("t2_compare2", 1, 2);
    step();
    start_pass(0, 1, 3'd7);
    wait_done("t2_clamp7", 7);

    // 3: backpressure at idx 1
    start_pass(1, 0, 3'd4);
    chk("t3_idx0", obs(), ev(1, 0, 1, 1, 0, 0, 2'd0));
    step();
    seg_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t3_hold", obs(), ev(1, 0, 1, 0, 0, 0, 2'd1));
      step();
    end
    seg_ready = 1'b1;
    chk("t3_resume", obs(), ev(1, 0, 1, 0, 0, 0, 2'd1));
    wait_done("t3_stall", 10);

    // 3b: en low two cycles in drain
    start_pass(1, 0, 3'd4);
    repeat (4) step();
    chk("t3b_drain", obs(), ev(1, 0, 0, 0, 0, 0, 2'd0));
    en = 1'b0;
    step();
    step();
    chk("t3b_frozen", obs(), ev(1, 0, 0, 0, 0, 0, 2'd0));
    en = 1'b1;
    wait_done("t3b_en_low", 9);

    // 4: keep 0, both starts, start while busy
    start_pass(0, 1, 3'd0);
    chk("t4_keep0_done", obs(), ev(0, 1, 0, 0, 0, 1, 2'd0));
    step();
    chk("t4_keep0_idle", obs(), ev(0, 0, 0, 0, 0, 1, 2'd0));
    start_pass(1, 1, 3'd2);
    chk("t4_both_mode", obs(), ev(1, 0, 1, 1, 0, 0, 2'd0));
    step();
    start_compare = 1'b1;
    step();
    start_compare = 1'b0;
    wait_done("t4_busy_start", 5);
    no_done("t4_no_second", 5);
    chk("t4_mode_kept", {31'd0, mode}, 32'd0);

    // 5: abort at idx 2, abort in drain
    start_pass(1, 0, 3'd4);
    step();
    step();
    chk("t5_idx2", obs(), ev(1, 0, 1, 0, 0, 0, 2'd2));
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t5_abort_issue", obs(), ev(0, 0, 0, 0, 0, 0, 2'd0));
    no_done("t5a", 5);
    start_pass(0, 1, 3'd2);
    step();
    step();
    chk("t5_in_drain", obs(), ev(1, 0, 0, 0, 0, 1, 2'd0));
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t5_abort_drain", obs(), ev(0, 0, 0, 0, 0, 1, 2'd0));
    no_done("t5b", 5);

    // 6: async reset mid-issue
    start_pass(0, 1, 3'd4);
    repeat (3) step();
    chk("t6_idx3", obs(), ev(1, 0, 1, 0, 1, 1, 2'd3));
    #2 rst = 1'b1;
    #1;
    chk("t6_async_rst", obs(), ev(0, 0, 0, 0, 0, 0, 2'd0));
    step();
    rst = 1'b0;
    step();
    start_pass(1, 0, 3'd4);
    issue_seq("t6_after_rst", 0, 4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end
endmodule
